timer_compare: RTL and testbench
================================

# timer_compare

Compare/event unit that reads the count stream produced by the team's up/down counter and raises an interrupt when the count reaches a programmed compare value. It is the consumer end of the counter interface: it sits beside a free-running counter in the CPU timer subsystem (mtimecmp-style) and drives an interrupt line into the interrupt controller. It supports one-shot and periodic modes and a pending/acknowledge handshake.

## Interface
- Width, 8, width of count, compare and period values
- clk  in  1  clock, all state updated on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- count  in  Width  current counter value
- count_valid  in  1  count changed this cycle (the counter's enable or load); compare only evaluated when high
- arm  in  1  pulse: capture cmp_wdata, period_wdata and periodic, enter ARMED
- disarm  in  1  pulse: return to IDLE
- periodic  in  1  mode sampled on arm: 1 = periodic, 0 = one-shot
- cmp_wdata  in  Width  compare value captured on arm
- period_wdata  in  Width  period captured on arm
- irq_ack  in  1  pulse: clear pending interrupt
- irq  out  1  level: interrupt pending
- fire  out  1  one-cycle pulse per match
- armed  out  1  state == ARMED
- cmp_value  out  Width  current compare register
- miss_count  out  Width  saturating count of matches lost while irq pending (TIMER_CMP_MISS_CNT_EN only)

## Operation
- States: IDLE, ARMED. Reset → IDLE; irq, fire, cmp_value, period, mode, miss_count all 0.
- Match: state == ARMED && count_valid && count == cmp_value.
- On match: fire = 1 next cycle; irq set next cycle.
  - One-shot, or periodic with period == 0: → IDLE.
  - Periodic, period != 0: cmp_value <= cmp_value + period, modulo 2^Width (wraps, no carry kept); stay ARMED.
- IDLE: count ignored; irq holds its value until acked.
- arm in any state: load cmp_value, period, mode; → ARMED. Does not clear irq or miss_count.
- disarm: → IDLE; irq, cmp_value unchanged.
- Priorities, same cycle:
  - disarm over arm: result IDLE, registers not reloaded.
  - arm over match: old-compare match discarded, no fire; new compare evaluated from next cycle.
  - match with irq_ack: irq stays 1 (ack consumes old event, new one pending); not a miss.
  - irq_ack without match: irq cleared next cycle; ack while irq == 0 has no effect.
- Miss: match while irq == 1 and no irq_ack same cycle.
- Equality compare only: a count that skips cmp_value (load or Increment > 1) produces no match.

## Timing
- Match to fire/irq: 1 cycle (registered outputs).
- irq_ack to irq low: 1 cycle.
- arm to armed high: 1 cycle; first possible match on the cycle after arm.
- Periodic reload takes effect on the cycle after the match; a count_valid on that same cycle already compares against the new value.
- rst_n assertion mid-operation: immediate asynchronous return to reset values; fire deasserts without completing a pulse.

## Configuration
- TIMER_CMP_MISS_CNT_EN defined: miss_count port and register present; increments by 1 per miss, saturates at 2^Width−1, cleared only by reset.
- Not defined: port and register absent; misses silently dropped, irq behaviour identical.

## Structure
- timer_pkg: state enum typedef (IDLE, ARMED), mode typedef (ONESHOT, PERIODIC).
- Sub-module: sat_counter (Width-bit saturating incrementer with enable, async active-low reset), instantiated only under TIMER_CMP_MISS_CNT_EN.

## Test plan
- Width=8, arm cmp=5 one-shot, count 0..10 with count_valid → single fire the cycle after count==5, irq=1, armed=0; irq_ack → irq=0 next cycle.
- Periodic cmp=250 period=10 → fires at 250, cmp_value=4 (wrap), fires again at count 4 after counter wrap.
- Match at count 20 with irq already pending and no ack → irq stays 1, miss_count=1; 300 such misses → miss_count=255.
- Same cycle: match + irq_ack → irq stays 1, miss_count unchanged; arm + disarm → armed=0, cmp_value unchanged.
- arm cmp=7 on the cycle count==3 matches old cmp=3 → no fire; later count==7 → fire.
- Count loads 2→9 skipping cmp=5 → no fire; rst_n low mid-ARMED → irq=0, armed=0, cmp_value=0 immediately.

Source files
------------

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared types for the timer compare unit (state and mode).
// Revision    : 1.0
// ============================================================================
package timer_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        ONESHOT  = 1'b0,
        PERIODIC = 1'b1
    } mode_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : WIDTH-bit incrementer with enable that sticks at all-ones.
// Revision    : 1.0
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (en && (r_value != {WIDTH{1'b1}})) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/timer_compare.sv
`default_nettype none
// ============================================================================
// Module      : timer_compare
// Description : Compare/event unit raising an interrupt when the counter hits
//               a programmed compare value; one-shot and periodic modes.
//               Optional miss counter under macro TIMER_CMP_MISS_CNT_EN.
// Revision    : 1.0
// ============================================================================
module timer_compare
    import timer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] count,
    input  logic             count_valid,
    input  logic             arm,
    input  logic             disarm,
    input  logic             periodic,
    input  logic [WIDTH-1:0] cmp_wdata,
    input  logic [WIDTH-1:0] period_wdata,
    input  logic             irq_ack,
    output logic             irq,
    output logic             fire,
    output logic             armed,
    output logic [WIDTH-1:0] cmp_value
`ifdef TIMER_CMP_MISS_CNT_EN
    ,
    output logic [WIDTH-1:0] miss_count
`endif
);

    state_t           r_state;
    state_t           w_next_state;
    mode_t            r_mode;
    logic [WIDTH-1:0] r_cmp;
    logic [WIDTH-1:0] r_period;
    logic             r_fire;
    logic             r_irq;

    logic             w_match;
    logic             w_reload;
    logic             w_load;

    // A command in the same cycle pre-empts the match against the old compare.
    assign w_match  = (r_state == ARMED) && count_valid && (count == r_cmp)
                      && !arm && !disarm;
    assign w_reload = w_match && (r_mode == PERIODIC) && (r_period != '0);
    assign w_load   = arm && !disarm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (disarm) begin
            w_next_state = IDLE;
        end else if (arm) begin
            w_next_state = ARMED;
        end else if (w_match && !w_reload) begin
            w_next_state = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode   <= ONESHOT;
            r_cmp    <= '0;
            r_period <= '0;
            r_fire   <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_fire <= w_match;
            // A new match outranks the ack: the ack retires the older event.
            if (w_match) begin
                r_irq <= 1'b1;
            end else if (irq_ack) begin
                r_irq <= 1'b0;
            end
            if (w_load) begin
                r_cmp    <= cmp_wdata;
                r_period <= period_wdata;
                r_mode   <= periodic ? PERIODIC : ONESHOT;
            end else if (w_reload) begin
                r_cmp <= r_cmp + r_period;
            end
        end
    end

    always_comb begin
        armed     = (r_state == ARMED);
        fire      = r_fire;
        irq       = r_irq;
        cmp_value = r_cmp;
    end

`ifdef TIMER_CMP_MISS_CNT_EN
    logic w_miss;

    assign w_miss = w_match && r_irq && !irq_ack;

    sat_counter #(
        .WIDTH (WIDTH)
    ) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_miss),
        .value (miss_count)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_timer_compare.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_compare
// Description : Directed table-driven bench for timer_compare plus hand
//               sequences for misses and asynchronous reset.
// Revision    : 1.0
// ============================================================================
module tb_timer_compare;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] count;
    logic             count_valid;
    logic             arm;
    logic             disarm;
    logic             periodic;
    logic [WIDTH-1:0] cmp_wdata;
    logic [WIDTH-1:0] period_wdata;
    logic             irq_ack;
    logic             irq;
    logic             fire;
    logic             armed;
    logic [WIDTH-1:0] cmp_value;
`ifdef TIMER_CMP_MISS_CNT_EN
    logic [WIDTH-1:0] miss_count;
`endif

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [7:0] cnt;
        logic       cv;
        logic       a;
        logic       d;
        logic       per;
        logic [7:0] cmp;
        logic [7:0] prd;
        logic       ack;
        logic       e_irq;
        logic       e_fire;
        logic       e_armed;
        logic [7:0] e_cmp;
    } vec_t;

    vec_t vecs[$];

    timer_compare #(
        .WIDTH (WIDTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .count        (count),
        .count_valid  (count_valid),
        .arm          (arm),
        .disarm       (disarm),
        .periodic     (periodic),
        .cmp_wdata    (cmp_wdata),
        .period_wdata (period_wdata),
        .irq_ack      (irq_ack),
        .irq          (irq),
        .fire         (fire),
        .armed        (armed),
        .cmp_value    (cmp_value)
`ifdef TIMER_CMP_MISS_CNT_EN
        ,
        .miss_count   (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    function automatic vec_t mk(input logic [7:0] cnt, input logic cv, input logic a,
                                input logic d, input logic per, input logic [7:0] cmp,
                                input logic [7:0] prd, input logic ack, input logic e_irq,
                                input logic e_fire, input logic e_armed, input logic [7:0] e_cmp);
        vec_t v;
        v.cnt = cnt; v.cv = cv; v.a = a; v.d = d; v.per = per; v.cmp = cmp;
        v.prd = prd; v.ack = ack; v.e_irq = e_irq; v.e_fire = e_fire;
        v.e_armed = e_armed; v.e_cmp = e_cmp;
        return v;
    endfunction

    task automatic idle_inputs();
        count = '0; count_valid = 1'b0; arm = 1'b0; disarm = 1'b0; periodic = 1'b0;
        cmp_wdata = '0; period_wdata = '0; irq_ack = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [7:0] cmp, input logic per, input logic [7:0] prd);
        idle_inputs();
        arm = 1'b1; cmp_wdata = cmp; periodic = per; period_wdata = prd;
        step();
        idle_inputs();
    endtask

    task automatic do_count(input logic [7:0] c, input logic ack);
        idle_inputs();
        count = c; count_valid = 1'b1; irq_ack = ack;
        step();
        idle_inputs();
    endtask

    initial begin
        // One-shot cmp=5, counting 0..10
        vecs.push_back(mk(0, 0, 1, 0, 0, 5, 0, 0,   0, 0, 1, 5));
        for (int c = 0; c <= 10; c++) begin
            vecs.push_back(mk(8'(c), 1, 0, 0, 0, 0, 0, 0,
                              (c >= 5), (c == 5), (c < 5), 5));
        end
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 5));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 5));
        // Periodic cmp=250 period=10: wraps to 4, second match together with an ack
        vecs.push_back(mk(0,   0, 1, 0, 1, 250, 10, 0,   0, 0, 1, 250));
        vecs.push_back(mk(249, 1, 0, 0, 0, 0,   0,  0,   0, 0, 1, 250));
        vecs.push_back(mk(250, 1, 0, 0, 0, 0,   0,  0,   1, 1, 1, 4));
        vecs.push_back(mk(255, 1, 0, 0, 0, 0,   0,  0,   1, 0, 1, 4));
        vecs.push_back(mk(0,   1, 0, 0, 0, 0,   0,  0,   1, 0, 1, 4));
        vecs.push_back(mk(4,   1, 0, 0, 0, 0,   0,  1,   1, 1, 1, 14));
        // disarm, then arm+disarm together
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,  0, 0,   1, 0, 0, 14));
        vecs.push_back(mk(0, 0, 1, 1, 0, 99, 0, 0,   1, 0, 0, 14));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1,   0, 0, 0, 14));
        // arm on the cycle the old compare matches
        vecs.push_back(mk(0, 0, 1, 0, 0, 3, 0, 0,   0, 0, 1, 3));
        vecs.push_back(mk(3, 1, 1, 0, 0, 7, 0, 0,   0, 0, 1, 7));
        vecs.push_back(mk(7, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 7));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 7));
        // count skipping the compare value, and equality without count_valid
        vecs.push_back(mk(0, 0, 1, 0, 0, 5, 0, 0,   0, 0, 1, 5));
        vecs.push_back(mk(2, 1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 5));
        vecs.push_back(mk(9, 1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 5));
        vecs.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 5));
        // periodic with period 0 behaves as one-shot
        vecs.push_back(mk(0, 0, 1, 0, 1, 8, 0, 0,   0, 0, 1, 8));
        vecs.push_back(mk(8, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 8));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 8));

        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk("reset irq", 32'(irq), 0);
        chk("reset fire", 32'(fire), 0);
        chk("reset armed", 32'(armed), 0);
        chk("reset cmp_value", 32'(cmp_value), 0);
`ifdef TIMER_CMP_MISS_CNT_EN
        chk("reset miss_count", 32'(miss_count), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            count = vecs[i].cnt; count_valid = vecs[i].cv; arm = vecs[i].a;
            disarm = vecs[i].d; periodic = vecs[i].per; cmp_wdata = vecs[i].cmp;
            period_wdata = vecs[i].prd; irq_ack = vecs[i].ack;
            step();
            chk($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].e_irq));
            chk($sformatf("vec%0d fire", i), 32'(fire), 32'(vecs[i].e_fire));
            chk($sformatf("vec%0d armed", i), 32'(armed), 32'(vecs[i].e_armed));
            chk($sformatf("vec%0d cmp_value", i), 32'(cmp_value), 32'(vecs[i].e_cmp));
        end
        idle_inputs();
`ifdef TIMER_CMP_MISS_CNT_EN
        chk("table miss_count", 32'(miss_count), 0);
`endif

        // Misses: match at 20 while irq already pending
        do_arm(20, 0, 0);
        do_count(20, 0);
        chk("first match irq", 32'(irq), 1);
        do_arm(20, 0, 0);
        do_count(20, 0);
        chk("miss irq", 32'(irq), 1);
        chk("miss fire", 32'(fire), 1);
`ifdef TIMER_CMP_MISS_CNT_EN
        chk("miss_count one", 32'(miss_count), 1);
`endif
        do_arm(20, 0, 0);
        do_count(20, 1);
        chk("match+ack irq", 32'(irq), 1);
        chk("match+ack fire", 32'(fire), 1);
`ifdef TIMER_CMP_MISS_CNT_EN
        chk("match+ack miss_count", 32'(miss_count), 1);
`endif
        for (int k = 0; k < 300; k++) begin
            do_arm(20, 0, 0);
            do_count(20, 0);
        end
        chk("after misses irq", 32'(irq), 1);
`ifdef TIMER_CMP_MISS_CNT_EN
        chk("miss_count saturated", 32'(miss_count), 255);
`endif

        // Asynchronous reset while ARMED and fire high
        do_arm(50, 1, 3);
        do_count(50, 0);
        chk("pre-reset fire", 32'(fire), 1);
        do_arm(60, 0, 0);
        chk("pre-reset armed", 32'(armed), 1);
        count = 8'd60; count_valid = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset fire", 32'(fire), 0);
        chk("async reset irq", 32'(irq), 0);
        chk("async reset armed", 32'(armed), 0);
        chk("async reset cmp_value", 32'(cmp_value), 0);
`ifdef TIMER_CMP_MISS_CNT_EN
        chk("async reset miss_count", 32'(miss_count), 0);
`endif
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
